encoder_nbits_serial: RTL and testbench
=======================================

// Module: encoder_nbits_serial
// PURPOSE
//   Inverse of the N-to-2^N decoder: turns a 2^N-bit multi-hot vector back into N-bit binary indices.
//   Captures the vector, then emits the index of every set bit, highest first, one per accepted
//   valid/ready transfer. Sits downstream of request/flag collectors (interrupt lines, bank selects).
//   Feeds a binary-index consumer; that consumer may re-decode the index with the N-to-2^N decoder.
// PARAMETERS
//   N   4   index width; vector width is W = 2**N (W is a localparam, N >= 1)
// PORTS
//   i_clk     in   1      clock, all state on rising edge
//   i_rst_n   in   1      asynchronous reset, active-low
//   i_EN      in   1      enable; gates i_load only
//   i_load    in   1      capture request (honoured only in IDLE with i_EN=1)
//   i_D       in   2**N   multi-hot input vector, sampled on the accepted load edge
//   i_ready   in   1      consumer ready for o_Y
//   o_Y       out  N      binary index of highest pending set bit
//   o_valid   out  1      o_Y valid
//   o_busy    out  1      1 in EMIT or DONE
//   o_done    out  1      one-cycle pulse: all indices of the captured vector emitted
//   o_none    out  1      captured vector was all-zero; held until the next accepted load
//   o_count   out  N+1    popcount of the captured vector, held until the next accepted load
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state=IDLE; pending register=0.
//     Reset values: o_Y=0, o_valid=0, o_busy=0, o_done=0, o_none=0, o_count=0.
//     Reset takes effect immediately, including mid-EMIT; the partially emitted vector is discarded.
//   States: IDLE, EMIT, DONE.
//   IDLE: o_valid=0, o_busy=0.
//     Accepted load (i_EN & i_load): pending<=i_D; o_count<=popcount(i_D); o_none<=(i_D==0).
//     Next state is EMIT if i_D!=0, else DONE.
//   EMIT: o_valid=1; o_Y = position of MSB-most set bit of pending (combinational from the register).
//     Transfer = o_valid & i_ready: clear that bit in pending.
//     If it was the last set bit -> DONE, else stay in EMIT; the next index is presented the next cycle.
//     While i_ready=0: pending, o_Y and o_valid hold stable (no change, no drop).
//   DONE: exactly one cycle; o_done=1, o_valid=0, o_busy=1; -> IDLE unconditionally.
//   Latency: load accepted at edge k -> first o_valid high after edge k (cycle k+1).
//     Zero vector: o_done high in cycle k+1, o_valid never asserts.
//   Throughput: 1 index/cycle with i_ready=1. m set bits take m EMIT cycles + 1 DONE cycle.
//     A new load is possible in the cycle after DONE.
//   i_load or i_EN activity outside IDLE is ignored. i_D changes outside the load edge are ignored.
//   i_EN=0 does not pause EMIT.
//   o_count is N+1 bits so that an all-ones vector reports 2**N without wrap.
//   o_Y is 0 whenever o_valid=0 (no stale index on the bus).
//   No X propagation: every register has a reset value; the priority scan has a defined result for pending=0 (o_Y=0).
// TESTING
//   T1 N=4, load 16'h8421, i_ready=1.
//      -> o_Y=15,10,5,0 on consecutive cycles with o_valid=1.
//      -> o_count=4, o_done pulse the cycle after o_Y=0, then IDLE.
//   T2 load 16'h0000.
//      -> o_valid stays 0; o_done=1 in cycle k+1; o_none=1, o_count=0 until the next load.
//   T3 load 16'h0003, i_ready=0 for 3 cycles, then 1.
//      -> o_Y=1 with o_valid=1 held for 4 cycles; then o_Y=0; then o_done.
//   T4 load 16'h0300, then i_load=1 with i_D=16'hFFFF during EMIT.
//      -> output sequence still 9,8; o_count=2; second load ignored.
//   T5 load 16'hFFFF with i_ready=1.
//      -> o_Y=15 down to 0 in 16 consecutive cycles; o_count=5'd16; o_done on cycle 17.
//   T6 i_rst_n low mid-EMIT of 16'h00F0 (after 2 transfers).
//      -> all outputs 0 immediately, asynchronously.
//      -> after release, load 16'h0001 gives o_Y=0, o_done, o_count=1.
//   All tests: i_EN=0 with i_load=1 in IDLE -> no state change, o_busy=0.

Source files
------------

// File: rtl/encoder_nbits_serial.sv
// Serial priority encoder: captures a 2**N-bit multi-hot vector, then emits the index of
// every set bit (highest first) as one valid/ready transfer per index.
module encoder_nbits_serial #(
  parameter int N = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_EN,
  input  logic              i_load,
  input  logic [2**N-1:0]   i_D,
  input  logic              i_ready,
  output logic [N-1:0]      o_Y,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_none,
  output logic [N:0]        o_count
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   pending, pending_nxt;
  logic [N-1:0]   top_idx;
  logic [W-1:0]   top_mask;
  logic           last_bit;
  logic           load_acc;
  logic [N:0]     pop;

  assign load_acc = (state == IDLE) && i_EN && i_load;

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + {{N{1'b0}}, i_D[i]};
    end
  end

  // Ascending scan so the highest set bit wins; an empty register yields index 0.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    top_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (pending[i]) top_idx = N'(i);
    end
  end

  assign top_mask = {{(W-1){1'b0}}, 1'b1} << top_idx;
  assign last_bit = (pending & ~top_mask) == '0;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (load_acc) begin
          pending_nxt = i_D;
          state_nxt   = (i_D != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (i_ready) begin
          pending_nxt = pending & ~top_mask;
          if (last_bit) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (!i_rst_n) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Summary flags describe the last accepted vector and hold until the next accepted load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
      o_none  <= 1'b0;
    end else if (load_acc) begin
      o_count <= pop;
      o_none  <= (i_D == '0);
    end
  end

  assign o_valid = (state == EMIT);
  assign o_Y     = o_valid ? top_idx : '0;
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

endmodule

// File: tb/tb_encoder_nbits_serial.sv
// Self-checking bench for encoder_nbits_serial: directed corner vectors plus random vectors,
// random ready stalls and ignored load noise, checked against a queue-based index model.
module tb_encoder_nbits_serial;

  localparam int N = 4;
  localparam int W = 2**N;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_EN;
  logic          i_load;
  logic [W-1:0]  i_D;
  logic          i_ready;
  logic [N-1:0]  o_Y;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_none;
  logic [N:0]    o_count;

  encoder_nbits_serial #(.N(N)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_EN    (i_EN),
    .i_load  (i_load),
    .i_D     (i_D),
    .i_ready (i_ready),
    .o_Y     (o_Y),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_none  (o_none),
    .o_count (o_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_q[$];
  int exp_count = 0;
  bit exp_none  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: list of set-bit positions from MSB to LSB, plus popcount and zero flag.
  task automatic build_ref(input logic [W-1:0] v);
    exp_q.delete();
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) exp_q.push_back(i);
    end
    exp_count = exp_q.size();
    exp_none  = (v == '0);
  endtask

  task automatic run_vec(input logic [W-1:0] v, input int stall, input bit rnd_ready);
    int  k;
    int  budget;
    bit  rdy;
    // A load with i_EN=0 in IDLE must not be accepted.
    @(negedge i_clk);
    i_EN    = 1'b0;
    i_load  = 1'b1;
    i_D     = W'($urandom);
    i_ready = 1'($urandom);
    @(posedge i_clk);
    @(negedge i_clk);
    check("en0_busy",  o_busy,  0);
    check("en0_valid", o_valid, 0);
    check("en0_y",     o_Y,     0);
    check("en0_count", o_count, exp_count);
    check("en0_none",  o_none,  exp_none);

    i_EN   = 1'b1;
    i_load = 1'b1;
    i_D    = v;
    build_ref(v);
    @(posedge i_clk);

    k      = 0;
    budget = 0;
    forever begin
      @(negedge i_clk);
      i_load = 1'($urandom);
      i_EN   = 1'($urandom);
      i_D    = W'($urandom);
      check("count", o_count, exp_count);
      check("none",  o_none,  exp_none);
      if (exp_q.size() > 0) begin
        rdy     = (k < stall) ? 1'b0 : (rnd_ready ? 1'($urandom) : 1'b1);
        i_ready = rdy;
        check("valid", o_valid, 1);
        check("y",     o_Y,     exp_q[0]);
        check("busy",  o_busy,  1);
        check("done",  o_done,  0);
        @(posedge i_clk);
        if (rdy) void'(exp_q.pop_front());
        k++;
      end else begin
        i_ready = 1'($urandom);
        check("done_valid", o_valid, 0);
        check("done_y",     o_Y,     0);
        check("done_busy",  o_busy,  1);
        check("done_pulse", o_done,  1);
        @(posedge i_clk);
        break;
      end
      budget++;
      if (budget > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: vector %h still emitting after %0d cycles", v, budget);
        break;
      end
    end

    @(negedge i_clk);
    i_load = 1'b0;
    check("idle_busy",  o_busy,  0);
    check("idle_done",  o_done,  0);
    check("idle_valid", o_valid, 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_EN    = 1'b0;
    i_load  = 1'b0;
    i_D     = '0;
    i_ready = 1'b0;
    #12;
    check("rst_y",     o_Y,     0);
    check("rst_valid", o_valid, 0);
    check("rst_busy",  o_busy,  0);
    check("rst_done",  o_done,  0);
    check("rst_none",  o_none,  0);
    check("rst_count", o_count, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_vec(16'h8421, 0, 1'b0);
    run_vec(16'h0000, 0, 1'b0);
    run_vec(16'h0003, 3, 1'b0);
    run_vec(16'h0300, 0, 1'b0);
    run_vec(16'hFFFF, 0, 1'b0);
    run_vec(16'h0001, 0, 1'b0);

    // Asynchronous reset in the middle of an emission.
    @(negedge i_clk);
    i_EN    = 1'b1;
    i_load  = 1'b1;
    i_D     = 16'h00F0;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_load = 1'b0;
    check("t6_y0", o_Y, 7);
    @(posedge i_clk);
    @(negedge i_clk);
    check("t6_y1", o_Y, 6);
    @(posedge i_clk);
    #2;
    check("t6_pre_valid", o_valid, 1);
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_y",     o_Y,     0);
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_busy",  o_busy,  0);
    check("t6_rst_done",  o_done,  0);
    check("t6_rst_none",  o_none,  0);
    check("t6_rst_count", o_count, 0);
    exp_count = 0;
    exp_none  = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_vec(16'h0001, 0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      if (r % 3 == 1) v = v & W'($urandom) & W'($urandom);
      if (r % 8 == 5) v = '0;
      run_vec(v, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
